// File: rtl/burst_dma_engine.sv
// Burst DMA master: moves 1..2^MAX_BURST_LOG2 words between the word buffer and the system bus; DMA_TIMEOUT_EN adds a watchdog.
// Write bursts stream one word per cycle using a lookahead buffer address and hold on busyIN; read data lands in the buffer one cycle after data_validIN.
module burst_dma_engine #(
   parameter int BUF_ADDR_WIDTH = 9,
   parameter int MAX_BURST_LOG2 = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start_write,
   input  logic                      start_read,
   input  logic [31:0]               start_address,
   input  logic [3:0]                start_byte_enable,
   input  logic [7:0]                burst_len,
   input  logic [BUF_ADDR_WIDTH-1:0] buf_start,
   output logic                      dma_ready,
   output logic                      dma_done,
   output logic                      dma_error,
   output logic [8:0]                words_done,
   output logic [BUF_ADDR_WIDTH-1:0] bufferAddress,
   output logic [31:0]               dataIn,
   output logic                      writeEnable,
   input  logic [31:0]               dataOut,
   input  logic [31:0]               address_dataIN,
   input  logic                      end_transactionIN,
   input  logic                      data_validIN,
   input  logic                      busyIN,
   input  logic                      errorIN,
   output logic [31:0]               address_dataOUT,
   output logic [3:0]                byte_enableOUT,
   output logic [7:0]                burst_sizeOUT,
   output logic                      read_n_writeOUT,
   output logic                      begin_transactionOUT,
   output logic                      end_transactionOUT,
   output logic                      data_validOUT,
   output logic                      busyOUT,
   output logic                      request,
   input  logic                      granted,
   output logic [3:0]                dma_state
);

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      PREFETCH  = 4'd1,
      REQ       = 4'd2,
      HANDSHAKE = 4'd3,
      WDATA     = 4'd4,
      RDATA     = 4'd5,
      WFLUSH    = 4'd6,
      FINISH    = 4'd7
   } state_t;

   state_t                    state, state_nxt;
   logic [31:0]               addr_q;
   logic [3:0]                be_q;
   logic [7:0]                len_q, len_m;
   logic                      rnw_q;
   logic [BUF_ADDR_WIDTH-1:0] ptr;
   logic [31:0]               wr_dat;
   logic                      pend;
   logic [8:0]                total, rx_total;
   logic                      last, accept, abort, tmo_hit;

   always_comb begin
      len_m = burst_len;
      for (int i = 0; i < 8; i++) begin
         if (i >= MAX_BURST_LOG2) len_m[i] = 1'b0;
      end
   end

   assign total    = {1'b0, len_q} + 9'd1;
   assign rx_total = words_done + {8'd0, data_validIN};
   assign last     = (words_done + 9'd1) == total;
   assign accept   = (state == IDLE) && (start_write || start_read);
   assign abort    = (state != IDLE) && (errorIN || tmo_hit);
   assign busyOUT  = 1'b0;
   assign dma_state = state;

`ifdef DMA_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] tmo_cnt;
   logic          counting, progress;

   always_comb begin
      counting = (state == REQ) || (state == WDATA) || (state == RDATA);
      progress = ((state == REQ) && granted) || ((state == WDATA) && !busyIN) ||
                 ((state == RDATA) && data_validIN);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                    tmo_cnt <= '0;
      else if (!counting || progress) tmo_cnt <= '0;
      else                           tmo_cnt <= tmo_cnt + 1'b1;
   end

   assign tmo_hit = counting && !progress && (tmo_cnt == TMO_LAST);
`else
   logic cfg_unused;
   assign cfg_unused = (TIMEOUT_CYCLES != 0);
   assign tmo_hit    = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:      if (start_write) state_nxt = PREFETCH;
                       else if (start_read) state_nxt = REQ;
            PREFETCH:  state_nxt = REQ;
            REQ:       if (granted) state_nxt = HANDSHAKE;
            HANDSHAKE: state_nxt = rnw_q ? RDATA : WDATA;
            WDATA:     if (!busyIN && last) state_nxt = FINISH;
            RDATA:     if (end_transactionIN) state_nxt = data_validIN ? WFLUSH : FINISH;
            WFLUSH:    state_nxt = FINISH;
            FINISH:    state_nxt = IDLE;
            default:   state_nxt = IDLE;
         endcase
      end
   end

   // In WDATA the address runs one word ahead so dataOut is ready on the next accepted cycle.
   always_comb begin
      dma_ready            = 1'b0;
      dma_done             = 1'b0;
      request              = 1'b0;
      begin_transactionOUT = 1'b0;
      end_transactionOUT   = 1'b0;
      data_validOUT        = 1'b0;
      address_dataOUT      = '0;
      byte_enableOUT       = '0;
      burst_sizeOUT        = '0;
      read_n_writeOUT      = 1'b0;
      bufferAddress        = ptr;
      writeEnable          = pend;
      dataIn               = pend ? wr_dat : '0;
      case (state)
         IDLE:      dma_ready = 1'b1;
         REQ:       request = 1'b1;
         HANDSHAKE: begin
            begin_transactionOUT = 1'b1;
            address_dataOUT      = addr_q;
            byte_enableOUT       = be_q;
            burst_sizeOUT        = len_q;
            read_n_writeOUT      = rnw_q;
            end_transactionOUT   = abort;
         end
         WDATA: begin
            data_validOUT      = 1'b1;
            address_dataOUT    = dataOut;
            end_transactionOUT = abort || (!busyIN && last);
            if (!busyIN) bufferAddress = ptr + 1'b1;
         end
         FINISH:    dma_done = !abort;
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         addr_q     <= '0;
         be_q       <= '0;
         len_q      <= '0;
         rnw_q      <= 1'b0;
         ptr        <= '0;
         wr_dat     <= '0;
         pend       <= 1'b0;
         words_done <= '0;
         dma_error  <= 1'b0;
      end else begin
         pend <= 1'b0;
         if (pend) ptr <= ptr + 1'b1;
         if (accept) begin
            addr_q     <= start_address;
            be_q       <= start_byte_enable;
            len_q      <= len_m;
            rnw_q      <= ~start_write;
            ptr        <= buf_start;
            words_done <= '0;
            dma_error  <= 1'b0;
         end
         if (abort) dma_error <= 1'b1;
         if (!abort && (state == WDATA) && !busyIN) begin
            ptr        <= ptr + 1'b1;
            words_done <= words_done + 9'd1;
         end
         if (!abort && (state == RDATA)) begin
            if (data_validIN) begin
               wr_dat     <= address_dataIN;
               pend       <= 1'b1;
               words_done <= words_done + 9'd1;
            end
            if (end_transactionIN && (rx_total < total)) dma_error <= 1'b1;
         end
      end
   end

endmodule

// File: doc/burst_dma_engine.md
Name: burst_dma_engine

Overview:
- Parametrised burst DMA master between the JTAG-side IP core, the shared on-chip word buffer and the system bus.
- Moves 1..256 32-bit words per transfer, in either direction:
  - buffer -> bus (write burst);
  - bus -> buffer (read burst).
- Arbitrates for the bus via request/granted and reports completion and error status back to the IP core.

Parameters:
BUF_ADDR_WIDTH, 9, buffer word-address width; buffer depth = 2^BUF_ADDR_WIDTH, pointer wraps modulo depth
MAX_BURST_LOG2, 8, max burst = 2^MAX_BURST_LOG2 words; burst_len bits above this are ignored (forced 0)
TIMEOUT_CYCLES, 1024, watchdog limit (used only with DMA_TIMEOUT_EN)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous active-low reset
start_write  in  1  one-cycle pulse: buffer -> bus burst
start_read  in  1  one-cycle pulse: bus -> buffer burst
start_address  in  32  bus word address, bits [1:0] must be 0
start_byte_enable  in  4  byte enables for the transfer
burst_len  in  8  words-1
buf_start  in  BUF_ADDR_WIDTH  first buffer word index
dma_ready  out  1  idle, accepts a start
dma_done  out  1  one-cycle pulse at transfer end
dma_error  out  1  sticky; cleared by next accepted start
words_done  out  9  words transferred in last/current burst
bufferAddress  out  BUF_ADDR_WIDTH  buffer word address
dataIn  out  32  buffer write data
writeEnable  out  1  buffer write strobe
dataOut  in  32  buffer read data, valid 1 cycle after bufferAddress
address_dataIN, end_transactionIN, data_validIN, busyIN, errorIN  in  32,1,1,1,1  bus inputs
address_dataOUT, byte_enableOUT, burst_sizeOUT, read_n_writeOUT  out  32,4,8,1  bus outputs
begin_transactionOUT, end_transactionOUT, data_validOUT, busyOUT  out  1 each  bus outputs
request  out  1  bus request to arbiter
granted  in  1  bus grant
dma_state  out  4  current FSM state (debug)

Behaviour:
- Reset (async, reset=0):
  - state IDLE;
  - all bus outputs, request, writeEnable, dataIn, dma_done and dma_error are 0;
  - dma_ready=1; words_done=0.
- Start acceptance:
  - a start is accepted only in IDLE; starts in any other state are ignored;
  - start_write and start_read together: write wins;
  - on acceptance, latch address, byte enable, burst_len and buf_start; clear dma_error and words_done.
- States and transitions:
  - IDLE -> PREFETCH (write) or REQ (read).
  - PREFETCH: drive bufferAddress=buf_start for 1 cycle -> REQ.
  - REQ: request=1 until granted, then -> HANDSHAKE.
  - HANDSHAKE, exactly 1 cycle:
    - begin_transactionOUT=1;
    - address_dataOUT=latched address;
    - byte_enableOUT=latched BE;
    - burst_sizeOUT=burst_len;
    - read_n_writeOUT=1 for read, else 0;
    - -> WDATA or RDATA.
  - WDATA:
    - data_validOUT=1, address_dataOUT=current word;
    - a word is accepted on a cycle with busyIN=0;
    - while busyIN=1, address_dataOUT holds stable;
    - after the last accepted word -> END.
  - RDATA:
    - each data_validIN=1 cycle writes address_dataIN to the buffer the next cycle (writeEnable=1, dataIn=word, bufferAddress=ptr), then ptr++;
    - end_transactionIN -> WFLUSH if a write is pending, else END.
  - WFLUSH: perform the pending buffer write -> END.
  - END: 1 cycle, dma_done=1 -> IDLE.
- WDATA throughput:
  - one word per cycle when busyIN=0, with no bubbles;
  - achieved with a lookahead buffer address or a skid register, given the 1-cycle buffer read latency;
  - end_transactionOUT=1 in the cycle the final word is accepted.
- Burst length: words transferred = burst_len+1, with burst_len bits at or above MAX_BURST_LOG2 forced to 0.
- Buffer pointer: starts at buf_start, increments per word, wraps modulo 2^BUF_ADDR_WIDTH.
- words_done increments per accepted or received word.
- Read burst ended by end_transactionIN before burst_len+1 words: dma_error=1, dma_done still pulses.
- errorIN=1 in any non-IDLE state:
  - abort immediately to IDLE next cycle;
  - dma_error=1;
  - end_transactionOUT=1 for that cycle only if the FSM is in HANDSHAKE/WDATA;
  - no dma_done.
- busyOUT is always 0.
- dma_ready=1 only in IDLE.

Optional Feature:
- Macro: DMA_TIMEOUT_EN.
- Defined:
  - a counter runs in REQ, WDATA and RDATA; it resets to 0 on any progress (granted, accepted word, data_validIN);
  - on reaching TIMEOUT_CYCLES: abort exactly as for errorIN (end_transactionOUT=1 if bus is owned), dma_error=1.
- Undefined: no counter; the FSM waits indefinitely.

Test Plan:
- Write, 4 words:
  - stimulus: start_write, address 0x40000010, BE 0xF, burst_len=3, buf_start=0, buffer preloaded 0xA0..0xA3, granted after 2 cycles, busyIN=0;
  - response: begin with addr 0x40000010, burst_sizeOUT=3; data 0xA0,0xA1,0xA2,0xA3 on 4 consecutive cycles; end_transactionOUT on 0xA3; dma_done; words_done=4.
- Write with stalls:
  - stimulus: same as above, with busyIN=1 on the cycles presenting words 1 and 2;
  - response: each stalled word is held stable; all 4 words are delivered in order; 6 data cycles in total.
- Read with wrap:
  - stimulus: start_read, burst_len=2, buf_start=511; bus returns 0x11,0x22,0x33 then end_transactionIN;
  - response: buffer[511]=0x11, buffer[0]=0x22, buffer[1]=0x33; dma_done; dma_error=0.
- Short read:
  - stimulus: burst_len=3, bus returns 2 words then end_transactionIN;
  - response: 2 buffer writes; dma_error=1; words_done=2; dma_done pulses.
- Error mid-write:
  - stimulus: errorIN=1 during the 2nd data word;
  - response: IDLE next cycle; dma_error=1; no dma_done; next start clears dma_error.
- Timeout (DMA_TIMEOUT_EN, TIMEOUT_CYCLES=16):
  - stimulus: granted is never asserted;
  - response: abort after 16 cycles in REQ; request=0; dma_error=1.
